// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS memory-side blocks: arbiter states, owner ids
// and default bus widths.
package mips_pkg;

   localparam int ADDR_W_DEF = 14;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } arb_state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_EXT = 1'b1;

endpackage

// File: rtl/arb_wait_counter.sv
// Counts arbitrations lost by the external port; saturates at 15 and flags
// when the external port must be forced to win.
module arb_wait_counter #(
   parameter int MAX_WAIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] cnt,
   output logic       force_ext
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                       cnt <= '0;
      else if (clr)                   cnt <= '0;
      else if (inc && cnt != 4'hF)    cnt <= cnt + 4'd1;
   end

   assign force_ext = (cnt >= 4'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port Dmem. Each access runs
// IDLE -> ISSUE -> DONE; CPU has priority, bounded by the ext wait counter.
module dmem_arbiter
   import mips_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int EXT_MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_ack,
   output logic [DATA_W-1:0] ext_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   arb_state_t state;
   logic       owner;
   logic       lat_we;
   logic       ext_win;
   logic       force_ext;
   logic [3:0] wait_cnt;
   cmd_t       cpu_cmd, ext_cmd, win_cmd;

   assign cpu_cmd = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
   assign ext_cmd = '{we: ext_we, addr: ext_addr, wdata: ext_wdata};
   assign ext_win = ext_req & (~cpu_req | force_ext);
   assign win_cmd = ext_win ? ext_cmd : cpu_cmd;

   arb_wait_counter #(.MAX_WAIT(EXT_MAX_WAIT)) u_wcnt (
      .clk       (clk),
      .rst       (rst),
      .inc       ((state == ST_IDLE) & ext_req & cpu_req & ~ext_win),
      .clr       ((state == ST_IDLE) & ext_win),
      .cnt       (wait_cnt),
      .force_ext (force_ext)
   );

   // mem_addr / mem_wdata double as the command latch for the transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         owner     <= OWN_CPU;
         lat_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         cpu_ack   <= 1'b0;
         ext_ack   <= 1'b0;
         cpu_rdata <= '0;
         ext_rdata <= '0;
      end else begin
         cpu_ack   <= 1'b0;
         ext_ack   <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cpu_req | ext_req) begin
                  owner     <= ext_win ? OWN_EXT : OWN_CPU;
                  lat_we    <= win_cmd.we;
                  mem_addr  <= win_cmd.addr;
                  mem_wdata <= win_cmd.wdata;
                  mem_read  <= ~win_cmd.we;
                  mem_write <= win_cmd.we;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!lat_we) begin
                  if (owner == OWN_EXT) ext_rdata <= mem_rdata;
                  else                  cpu_rdata <= mem_rdata;
               end
               if (owner == OWN_EXT) ext_ack <= 1'b1;
               else                  cpu_ack <= 1'b1;
               state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
